// File: rtl/dcache_axi_pkg.sv
// Shared types and constants for the data-cache to AXI3 bridge.
// Holds the bridge FSM encoding and the fixed AXI burst attributes.
package dcache_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } bridge_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

  // Byte-offset width of a cache line: word index bits plus the two byte bits.
  function automatic int unsigned line_off_bits(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/dcache_axi_bridge.sv
// Converts word-at-a-time cache refill/write-back requests into AXI3 INCR
// line bursts and hands per-word accept/complete pulses back to the cache.
module dcache_axi_bridge
  import dcache_axi_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  AXI_ID     = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        wlast,
  output logic [31:0] mem_rdata,
  output logic        mem_addr_ok,
  output logic        mem_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        axi_wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic        proto_err
);

  localparam int unsigned    CNT_W     = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [7:0]     BURST_LEN = 8'(LINE_WORDS - 1);
  localparam logic [31:0]    LINE_MASK = ~((32'd1 << line_off_bits(LINE_WORDS)) - 32'd1);

  bridge_state_t    state_r, next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      addr_r;
  logic             proto_err_r;
  logic             addr_ld_s, cnt_inc_s, ok_s, perr_set_s, last_beat_s;
  logic             arvalid_s, awvalid_s, rready_s, wvalid_s, bready_s;

  assign last_beat_s = (state_r == ST_W) && (cnt_r == LAST_BEAT);
  // The cache's own wlast is only cross-checked, never forwarded to AXI.
  assign perr_set_s  = wvalid_s & wready & (wlast != last_beat_s);

  // State, beat counter, latched line address and sticky protocol error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      addr_r      <= 32'd0;
      proto_err_r <= 1'b0;
    end else begin
      state_r <= next_s;
      if (addr_ld_s) begin
        addr_r <= mem_addr & LINE_MASK;
        cnt_r  <= {CNT_W{1'b0}};
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (perr_set_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  // Next-state decode and per-state AXI handshake signals.
  always_comb begin
    next_s    = state_r;
    addr_ld_s = 1'b0;
    cnt_inc_s = 1'b0;
    ok_s      = 1'b0;
    arvalid_s = 1'b0;
    awvalid_s = 1'b0;
    rready_s  = 1'b0;
    wvalid_s  = 1'b0;
    bready_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_req) begin
          addr_ld_s = 1'b1;
          next_s    = mem_wen ? ST_AW : ST_AR;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_AR: begin
        arvalid_s = 1'b1;
        next_s    = arready ? ST_R : ST_AR;
      end
      ST_R: begin
        rready_s = 1'b1;
        if (rvalid) begin
          ok_s      = 1'b1;
          cnt_inc_s = 1'b1;
          next_s    = rlast ? ST_IDLE : ST_R;
        end else begin
          next_s = ST_R;
        end
      end
      ST_AW: begin
        awvalid_s = 1'b1;
        next_s    = awready ? ST_W : ST_AW;
      end
      ST_W: begin
        wvalid_s = mem_req & mem_wen;
        if (wvalid_s && wready) begin
          cnt_inc_s = 1'b1;
          // Final word is acknowledged only once the write response arrives.
          if (last_beat_s) begin
            next_s = ST_B;
          end else begin
            ok_s   = 1'b1;
            next_s = ST_W;
          end
        end else begin
          next_s = ST_W;
        end
      end
      ST_B: begin
        bready_s = 1'b1;
        if (bvalid) begin
          ok_s   = 1'b1;
          next_s = ST_IDLE;
        end else begin
          next_s = ST_B;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  assign mem_rdata   = rdata;
  assign mem_addr_ok = ok_s;
  assign mem_data_ok = ok_s;
  assign arid        = AXI_ID;
  assign araddr      = addr_r;
  assign arlen       = BURST_LEN;
  assign arsize      = AXI_SIZE_WORD;
  assign arburst     = AXI_BURST_INCR;
  assign arvalid     = arvalid_s;
  assign rready      = rready_s;
  assign awid        = AXI_ID;
  assign awaddr      = addr_r;
  assign awlen       = BURST_LEN;
  assign awsize      = AXI_SIZE_WORD;
  assign awburst     = AXI_BURST_INCR;
  assign awvalid     = awvalid_s;
  assign wid         = AXI_ID;
  assign wdata       = mem_wdata;
  assign wstrb       = 4'hF;
  assign axi_wlast   = last_beat_s;
  assign wvalid      = wvalid_s;
  assign bready      = bready_s;
  assign proto_err   = proto_err_r;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: refills, write-backs, stalls,
// cache wlast mismatch, mid-burst reset and a mid-write request gap.
module tb_dcache_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_wen, wlast_c;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [3:0]  arid, awid, wid, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, axi_wlast, wvalid, wready, bvalid, bready, proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_axi_bridge #(.LINE_WORDS(8), .AXI_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wlast(wlast_c), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .axi_wlast(axi_wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .proto_err(proto_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
    check_eq({tag, "_awvalid"}, {31'd0, awvalid}, 32'd0);
    check_eq({tag, "_wvalid"}, {31'd0, wvalid}, 32'd0);
    check_eq({tag, "_rready"}, {31'd0, rready}, 32'd0);
    check_eq({tag, "_bready"}, {31'd0, bready}, 32'd0);
    check_eq({tag, "_addr_ok"}, {31'd0, mem_addr_ok}, 32'd0);
    check_eq({tag, "_data_ok"}, {31'd0, mem_data_ok}, 32'd0);
    check_eq({tag, "_araddr"}, araddr, 32'd0);
    check_eq({tag, "_awaddr"}, awaddr, 32'd0);
    check_eq({tag, "_perr"}, {31'd0, proto_err}, 32'd0);
  endtask

  // Refill one line; abort_at >= 0 pulses reset in R instead of that beat.
  task automatic refill(input logic [31:0] a, input logic [31:0] ea, input int stall,
                        input logic [31:0] base, input int abort_at);
    bit aborted = 1'b0;
    step(); mem_req = 1'b1; mem_wen = 1'b0; mem_addr = a; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    #1 check_eq("rf_idle_arvalid", {31'd0, arvalid}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      step(); mem_req = 1'b0; arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      #1 check_eq("rf_stall_arvalid", {31'd0, arvalid}, 32'd1);
      check_eq("rf_stall_rready", {31'd0, rready}, 32'd0);
      check_eq("rf_stall_data_ok", {31'd0, mem_data_ok}, 32'd0);
    end
    step(); mem_req = 1'b0; arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1 check_eq("rf_ar_arvalid", {31'd0, arvalid}, 32'd1);
    check_eq("rf_ar_araddr", araddr, ea);
    check_eq("rf_ar_arlen", {24'd0, arlen}, 32'd7);
    check_eq("rf_ar_data_ok", {31'd0, mem_data_ok}, 32'd0);
    check_eq("rf_ar_rready", {31'd0, rready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (!aborted) begin
        step(); arready = 1'b0; rvalid = 1'b1; rdata = base + 32'(i); rlast = (i == 7);
        if (i == abort_at) begin
          rvalid = 1'b0; rlast = 1'b0; reset = 1'b0;
          step(); reset = 1'b1;
          #1 check_idle_outputs("rst_mid_r");
          aborted = 1'b1;
        end else begin
          #1 check_eq("rf_r_rready", {31'd0, rready}, 32'd1);
          check_eq("rf_r_data_ok", {31'd0, mem_data_ok}, 32'd1);
          check_eq("rf_r_addr_ok", {31'd0, mem_addr_ok}, 32'd1);
          check_eq("rf_r_rdata", mem_rdata, base + 32'(i));
        end
      end
    end
    if (!aborted) begin
      step(); rvalid = 1'b0; rlast = 1'b0;
      #1 check_eq("rf_end_rready", {31'd0, rready}, 32'd0);
      check_eq("rf_end_arvalid", {31'd0, arvalid}, 32'd0);
    end
  endtask

  // Write back one line; tog toggles wready, err_beat raises cache wlast early,
  // gap_beat drops mem_req for three cycles before that beat.
  task automatic writeback(input logic [31:0] a, input logic [31:0] ea, input logic [31:0] base,
                           input bit tog, input int err_beat, input int gap_beat);
    int k = 0;
    int gap = 0;
    bit wr_tgl = 1'b0;
    step(); mem_req = 1'b1; mem_wen = 1'b1; mem_addr = a; mem_wdata = base; wlast_c = 1'b0; awready = 1'b0;
    #1 check_eq("wb_idle_awvalid", {31'd0, awvalid}, 32'd0);
    step(); awready = 1'b1;
    #1 check_eq("wb_aw_awvalid", {31'd0, awvalid}, 32'd1);
    check_eq("wb_aw_awaddr", awaddr, ea);
    check_eq("wb_aw_awlen", {24'd0, awlen}, 32'd7);
    check_eq("wb_aw_wvalid", {31'd0, wvalid}, 32'd0);
    for (int cyc = 0; cyc < 60 && k < 8; cyc++) begin
      step(); awready = 1'b0;
      if (gap_beat == k && gap < 3) begin
        mem_req = 1'b0; wready = 1'b1; gap++;
        #1 check_eq("wb_gap_wvalid", {31'd0, wvalid}, 32'd0);
        check_eq("wb_gap_data_ok", {31'd0, mem_data_ok}, 32'd0);
      end else begin
        mem_req = 1'b1; mem_wdata = base + 32'(k);
        wlast_c = (k == 7) || (k == err_beat);
        wready = tog ? wr_tgl : 1'b1;
        wr_tgl = ~wr_tgl;
        #1 check_eq("wb_w_wvalid", {31'd0, wvalid}, 32'd1);
        check_eq("wb_w_wdata", wdata, base + 32'(k));
        check_eq("wb_w_perr", {31'd0, proto_err}, {31'd0, (err_beat >= 0 && k > err_beat)});
        if (wready) begin
          check_eq("wb_w_axi_wlast", {31'd0, axi_wlast}, {31'd0, (k == 7)});
          check_eq("wb_w_data_ok", {31'd0, mem_data_ok}, {31'd0, (k < 7)});
          check_eq("wb_w_addr_ok", {31'd0, mem_addr_ok}, {31'd0, (k < 7)});
          k++;
        end else begin
          check_eq("wb_w_stall_data_ok", {31'd0, mem_data_ok}, 32'd0);
        end
      end
    end
    check_eq("wb_beats", 32'(k), 32'd8);
    step(); mem_req = 1'b0; wlast_c = 1'b0; wready = 1'b0; bvalid = 1'b0;
    #1 check_eq("wb_b_bready", {31'd0, bready}, 32'd1);
    check_eq("wb_b_wvalid", {31'd0, wvalid}, 32'd0);
    check_eq("wb_b_wait_data_ok", {31'd0, mem_data_ok}, 32'd0);
    step(); bvalid = 1'b1;
    #1 check_eq("wb_b_data_ok", {31'd0, mem_data_ok}, 32'd1);
    check_eq("wb_b_addr_ok", {31'd0, mem_addr_ok}, 32'd1);
    step(); bvalid = 1'b0;
    #1 check_eq("wb_end_bready", {31'd0, bready}, 32'd0);
    check_eq("wb_end_perr", {31'd0, proto_err}, {31'd0, (err_beat >= 0)});
  endtask

  initial begin
    reset = 1'b0; mem_req = 1'b0; mem_wen = 1'b0; wlast_c = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    arready = 1'b0; rdata = 32'd0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    step(); step(); reset = 1'b1;
    #1 check_idle_outputs("reset");
    check_eq("const_arid", {28'd0, arid}, 32'd1);
    check_eq("const_wstrb", {28'd0, wstrb}, 32'hF);
    check_eq("const_arburst", {30'd0, arburst}, 32'd1);
    check_eq("const_awsize", {29'd0, awsize}, 32'd2);

    refill(32'h1000_0014, 32'h1000_0000, 0, 32'd0, -1);
    writeback(32'h2000_0020, 32'h2000_0020, 32'hA000_0000, 1'b1, -1, -1);
    refill(32'h3000_0008, 32'h3000_0000, 5, 32'h300, -1);
    writeback(32'h6000_0040, 32'h6000_0040, 32'h600, 1'b0, 2, -1);
    refill(32'h7000_0010, 32'h7000_0000, 0, 32'h700, 4);
    refill(32'h4000_003C, 32'h4000_0020, 0, 32'h400, -1);
    writeback(32'h5000_0004, 32'h5000_0000, 32'h500, 1'b0, -1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_axi_bridge.md
# dcache_axi_bridge

Memory-side bridge directly downstream of the data cache. It turns the cache's word-at-a-time refill and write-back requests into AXI3 line bursts: one read burst per refill, and one write burst plus its response per write-back. It returns the per-word `mem_addr_ok`/`mem_data_ok` pulses the cache controller advances on.

## Interface
Parameters:
- `LINE_WORDS`, 8: words per cache line, a power of two; equals the cache's `OFFSET_SIZE`.
- `AXI_ID`, 4'd1: ID driven on `arid`, `awid` and `wid`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-low.
- `mem_req` in 1: cache request valid.
- `mem_wen` in 1: 1 = write-back word, 0 = refill word.
- `mem_addr` in 32: word address from the cache.
- `mem_wdata` in 32: write-back word.
- `wlast` in 1: the cache marks its final write-back word.
- `mem_rdata` out 32: refill word; equals `rdata` combinationally.
- `mem_addr_ok` out 1: word accepted.
- `mem_data_ok` out 1: word complete.
- `araddr` out 32, `arlen` out 8, `arvalid` out 1, `arready` in 1: AXI read address channel.
- `rdata` in 32, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI read data channel; `rid` and `rresp` are ignored.
- `awaddr` out 32, `awlen` out 8, `awvalid` out 1, `awready` in 1: AXI write address channel.
- `wdata` out 32, `wlast` out 1 (port `axi_wlast`), `wvalid` out 1, `wready` in 1: AXI write data channel.
- `bvalid` in 1, `bready` out 1: AXI write response; `bresp` is ignored.
- Constant outputs: `arid`/`awid`/`wid` = `AXI_ID`; `arsize`/`awsize` = 3'd2; `arburst`/`awburst` = 2'b01 (INCR); `wstrb` = 4'hF.
- `proto_err` out 1: sticky flag, set when the cache's `wlast` and the beat count disagree.

## Operation
- State machine states: IDLE, AR, R, AW, W, B.
- IDLE:
  - On `mem_req`, latch the line address `{mem_addr[31:log2(LINE_WORDS)+2], 0}`.
  - Clear the beat counter.
  - Go to AR if `mem_wen`=0, otherwise AW.
- AR: `arvalid`=1, `arlen`=`LINE_WORDS-1`. On `arready`, go to R.
- R:
  - `rready`=1.
  - Each `rvalid` beat pulses `mem_addr_ok` and `mem_data_ok` in the same cycle and increments the counter.
  - On `rlast`, return to IDLE.
- AW: `awvalid`=1, `awlen`=`LINE_WORDS-1`. On `awready`, go to W.
- W:
  - `wvalid` = `mem_req & mem_wen`; `wdata` = `mem_wdata`.
  - `axi_wlast` comes from the counter (`cnt == LINE_WORDS-1`), never from the cache's `wlast`.
  - A non-last handshake pulses both ok signals and increments the counter.
  - The last handshake produces no ok pulse and goes to B.
- B: `bready`=1. On `bvalid`, pulse both ok signals (completing the final word) and go to IDLE.
- `proto_err` is set when a W handshake has cache `wlast` != `axi_wlast`. It is cleared only by reset.
- The counter is `log2(LINE_WORDS)` bits wide and wraps to 0 on the final beat.

## Timing
- Reset values:
  - State IDLE, counter 0, `proto_err` 0.
  - `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`, `mem_addr_ok`, `mem_data_ok` all 0.
  - `araddr`/`awaddr` 0.
- `arvalid`/`awvalid` rise the cycle after `mem_req` is seen in IDLE. They stay high until the handshake.
- Ok pulses and `mem_rdata` are combinational from the AXI handshake, with zero added latency.
- Minimum refill latency with an always-ready slave: request in cycle 0, AR in cycle 1, first `mem_data_ok` in cycle 2, one word per cycle after that.
- `mem_req` dropping mid-write deasserts `wvalid`. The counter holds and no beat is lost.
- `mem_req` is ignored outside IDLE and W.
- An `rvalid` that arrives in the same cycle as the AR handshake is not accepted, because `rready` is 0 in AR.
- A reset in any state returns to IDLE immediately and abandons the outstanding burst. The whole system resets together.

## Structure
- Package `dcache_axi_pkg` holds:
  - the state enum `bridge_state_t`;
  - `AXI_BURST_INCR` = 2'b01 and `AXI_SIZE_WORD` = 3'd2;
  - the `$clog2` helper constant for the line offset.
- Single module, no sub-module. The beat counter and FSM are too small to split out.

## Test plan
- Refill at `mem_addr`=0x1000_0014, `LINE_WORDS`=8, slave always ready:
  - `araddr`=0x1000_0000, `arlen`=7;
  - 8 `mem_data_ok` pulses carrying `rdata` 0..7;
  - IDLE again after `rlast`.
- Write-back of 8 words at 0x2000_0020, `wready` toggling every cycle:
  - `awaddr`=0x2000_0020;
  - 8 W beats with `axi_wlast` only on the 8th;
  - 7 ok pulses during W, the 8th on `bvalid`.
- `arready` held low for 5 cycles: `arvalid` stays 1 throughout, with no ok pulses and no `rready`.
- Cache `wlast` asserted on beat 3: the AXI burst still carries 8 beats, and `proto_err`=1 from the next cycle.
- Reset (`reset`=0) held for one cycle during R at beat 4: all outputs return to their reset values the next cycle, and a new refill proceeds normally.
- `mem_req` dropped for 3 cycles mid-write: `wvalid`=0 during the gap, and `wdata` order is preserved.
